// File: rtl/bcu_pkg.sv
// Shared definitions for the branch control unit: opcode encoding, flag bit
// positions and instruction size.
package bcu_pkg;

  typedef enum logic [3:0] {
    OpJge  = 4'b1001,
    OpJlt  = 4'b1010,
    OpRet  = 4'b1011,
    OpJmp  = 4'b1100,
    OpJeq  = 4'b1101,
    OpJne  = 4'b1110,
    OpCall = 4'b1111
  } opcode_e;

  // Bit positions inside the {N,Z,C,V} flag vector
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  localparam int unsigned INSTR_BYTES = 4;

  // Signed less-than from a completed compare: N differs from V
  function automatic logic flags_lt(input logic [3:0] flags);
    return flags[FLAG_N] ^ flags[FLAG_V];
  endfunction

endpackage

// File: rtl/en_reg.sv
// Enabled register with synchronous active-high reset. Reset wins over enable.
module en_reg #(
  parameter int unsigned     WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // State update: reset first, then load when enabled
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/return_stack.sv
// Circular return-address stack. A push while full overwrites the oldest
// entry (the write pointer has wrapped onto it) and the count saturates.
// A pop while empty is ignored. Only pointer and count are reset.
module return_stack #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gen_bad_depth
    $error("return_stack: DEPTH must be a power of two and at least 2");
  end

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] wr_en;

  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);
  // Top of stack sits just below the write pointer
  assign data  = mem_q[ptr_q - PTR_W'(1)];

  // Pointer/count next state; push has priority, empty pops are dropped
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push) begin
      ptr_d = ptr_q + PTR_W'(1);
      if (!full) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (pop && !empty) begin
      ptr_d = ptr_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Per-entry write enables decoded from the write pointer
  always_comb begin
    wr_en = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wr_en[i] = push && (ptr_q == PTR_W'(i));
    end
  end

  en_reg #(.WIDTH(PTR_W)) u_ptr (
    .clk  (clk),
    .reset(reset),
    .en   (1'b1),
    .d    (ptr_d),
    .q    (ptr_q)
  );

  en_reg #(.WIDTH(CNT_W)) u_cnt (
    .clk  (clk),
    .reset(reset),
    .en   (1'b1),
    .d    (cnt_d),
    .q    (cnt_q)
  );

  for (genvar i = 0; i < DEPTH; i++) begin : gen_entry
    // Entry contents are never reset
    en_reg #(.WIDTH(WIDTH)) u_entry (
      .clk  (clk),
      .reset(1'b0),
      .en   (wr_en[i]),
      .d    (push_data),
      .q    (mem_q[i])
    );
  end

endmodule

// File: rtl/branch_control_unit.sv
// Branch control unit: registered PC with conditional jumps, call/return via
// a return-address stack, and a flag register fed from the ALU.
// Build option BCU_RELATIVE_BRANCH_EN: when defined, branch targets are
// PC-relative word offsets; otherwise Imm is an absolute byte address.
module branch_control_unit
  import bcu_pkg::*;
#(
  parameter int unsigned      PC_W      = 32,
  parameter int unsigned      IMM_W     = 18,
  parameter int unsigned      RAS_DEPTH = 4,
  parameter logic [PC_W-1:0]  RESET_PC  = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stall,
  input  logic             valid,
  input  logic [3:0]       Id,
  input  logic [IMM_W-1:0] Imm,
  input  logic             FlagsWrite,
  input  logic [3:0]       ALUFlags,
  output logic [PC_W-1:0]  PCNext,
  output logic [3:0]       Flags,
  output logic             FlagZero,
  output logic             taken,
  output logic             ras_ovf,
  output logic             ras_udf
);

  if (IMM_W > PC_W) begin : gen_bad_imm
    $error("branch_control_unit: IMM_W must not exceed PC_W");
  end

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] seq_pc, target;
  logic [PC_W-1:0] ras_data;
  logic [3:0]      flags_q;
  logic            taken_q, taken_d;
  logic            ovf_q, ovf_d;
  logic            udf_q, udf_d;
  logic            advance, jump;
  logic            push, pop;
  logic            ras_full, ras_empty;

  // Reset also blocks advance so nothing is pushed or popped that cycle
  assign advance = start && !stall && !reset;
  assign seq_pc  = pc_q + PC_W'(INSTR_BYTES);

`ifdef BCU_RELATIVE_BRANCH_EN
  assign target = pc_q + (PC_W'($signed(Imm)) << 2);
`else
  assign target = PC_W'(Imm);
`endif

  // Next PC, stack control and sticky error flags; conditions use registered flags
  always_comb begin
    pc_d    = pc_q;
    taken_d = 1'b0;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    push    = 1'b0;
    pop     = 1'b0;
    jump    = 1'b0;
    if (advance) begin
      pc_d = seq_pc;
      if (valid) begin
        case (Id)
          OpJmp: jump = 1'b1;
          OpJeq: jump = flags_q[FLAG_Z];
          OpJne: jump = !flags_q[FLAG_Z];
          OpJlt: jump = flags_lt(flags_q);
          OpJge: jump = !flags_lt(flags_q);
          OpCall: begin
            jump = 1'b1;
            push = 1'b1;
            if (ras_full) begin
              ovf_d = 1'b1;
            end
          end
          OpRet: begin
            if (ras_empty) begin
              udf_d = 1'b1;
            end else begin
              pop     = 1'b1;
              pc_d    = ras_data;
              taken_d = 1'b1;
            end
          end
          default: jump = 1'b0;
        endcase
        if (jump) begin
          pc_d    = target;
          taken_d = 1'b1;
        end
      end
    end
  end

  en_reg #(.WIDTH(PC_W), .RESET_VAL(RESET_PC)) u_pc (
    .clk  (clk),
    .reset(reset),
    .en   (1'b1),
    .d    (pc_d),
    .q    (pc_q)
  );

  en_reg #(.WIDTH(4)) u_flags (
    .clk  (clk),
    .reset(reset),
    .en   (FlagsWrite),
    .d    (ALUFlags),
    .q    (flags_q)
  );

  en_reg #(.WIDTH(3)) u_status (
    .clk  (clk),
    .reset(reset),
    .en   (1'b1),
    .d    ({taken_d, ovf_d, udf_d}),
    .q    ({taken_q, ovf_q, udf_q})
  );

  return_stack #(.WIDTH(PC_W), .DEPTH(RAS_DEPTH)) u_ras (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .push_data(seq_pc),
    .data     (ras_data),
    .full     (ras_full),
    .empty    (ras_empty)
  );

  assign PCNext   = pc_q;
  assign Flags    = flags_q;
  assign FlagZero = flags_q[FLAG_Z];
  assign taken    = taken_q;
  assign ras_ovf  = ovf_q;
  assign ras_udf  = udf_q;

endmodule

// File: tb/tb_branch_control_unit.sv
// Directed bench for branch_control_unit with hand-derived expectations.
// A second instance with a high reset PC exercises the PC wrap.
module tb_branch_control_unit;

  logic        clk = 1'b0;
  logic        reset, start, stall, valid, FlagsWrite, start_w;
  logic [3:0]  Id, ALUFlags;
  logic [17:0] Imm;
  logic [31:0] pc, pc_w;
  logic [3:0]  flags, flags_w;
  logic        fz, taken, ovf, udf, fz_w, taken_w, ovf_w, udf_w;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_pc;
  logic [31:0] ra [5];
  logic [31:0] ra0;

  localparam logic [3:0] JGE = 4'b1001, JLT = 4'b1010, RET = 4'b1011, JMP = 4'b1100;
  localparam logic [3:0] JEQ = 4'b1101, JNE = 4'b1110, CALL = 4'b1111;

  always #5 clk = ~clk;

  branch_control_unit dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .valid(valid), .Id(Id),
    .Imm(Imm), .FlagsWrite(FlagsWrite), .ALUFlags(ALUFlags), .PCNext(pc), .Flags(flags),
    .FlagZero(fz), .taken(taken), .ras_ovf(ovf), .ras_udf(udf)
  );

  branch_control_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .reset(reset), .start(start_w), .stall(1'b0), .valid(1'b0), .Id(4'b0000),
    .Imm(18'h0), .FlagsWrite(1'b0), .ALUFlags(4'b0000), .PCNext(pc_w), .Flags(flags_w),
    .FlagZero(fz_w), .taken(taken_w), .ras_ovf(ovf_w), .ras_udf(udf_w)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] tgt(input logic [31:0] cur, input logic [17:0] imm);
`ifdef BCU_RELATIVE_BRANCH_EN
    return cur + ({{14{imm[17]}}, imm} << 2);
`else
    return {14'b0, imm};
`endif
  endfunction

  task automatic issue(input logic [3:0] op, input logic [17:0] imm);
    valid = 1'b1;
    Id    = op;
    Imm   = imm;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stall = 1'b0; valid = 1'b0; Id = 4'b0; Imm = '0;
    FlagsWrite = 1'b0; ALUFlags = 4'b0; start_w = 1'b0;
    step(); step();
    check("rst_pc", pc, 32'h0);
    check("rst_flags", {28'b0, flags}, 32'h0);
    check("rst_fz", {31'b0, fz}, 32'h0);
    check("rst_taken", {31'b0, taken}, 32'h0);
    check("rst_ovf", {31'b0, ovf}, 32'h0);
    check("rst_udf", {31'b0, udf}, 32'h0);
    check("rst_pc_w", pc_w, 32'hFFFF_FFF8);

    // Sequential fetch, plus wrap on the second instance
    reset = 1'b0; start = 1'b1; start_w = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      check("seq_pc", pc, 32'(4 * i));
      check("seq_taken", {31'b0, taken}, 32'h0);
      check("wrap_pc", pc_w, 32'hFFFF_FFF8 + 32'(4 * i));
    end
    exp_pc = 32'd12;

    // start low holds PC even with a jump presented
    start = 1'b0; issue(JMP, 18'h40); step();
    check("hold_pc", pc, exp_pc);
    check("hold_taken", {31'b0, taken}, 32'h0);
    start = 1'b1;

    // Flag write in the same cycle as JEQ: branch sees old Z=0
    FlagsWrite = 1'b1; ALUFlags = 4'b0100; issue(JEQ, 18'h40); step();
    exp_pc += 4;
    check("jeq_oldflag_pc", pc, exp_pc);
    check("jeq_oldflag_taken", {31'b0, taken}, 32'h0);
    check("flags_z", {28'b0, flags}, 32'h4);
    check("flagzero", {31'b0, fz}, 32'h1);
    FlagsWrite = 1'b0; step();
    exp_pc = tgt(exp_pc, 18'h40);
    check("jeq_pc", pc, exp_pc);
    check("jeq_taken", {31'b0, taken}, 32'h1);
    valid = 1'b0; step();
    exp_pc += 4;
    check("after_jeq_pc", pc, exp_pc);
    check("taken_pulse", {31'b0, taken}, 32'h0);
    issue(JNE, 18'h80); step();
    exp_pc += 4;
    check("jne_pc", pc, exp_pc);
    check("jne_taken", {31'b0, taken}, 32'h0);

    // N=1, V=0: JLT taken, JGE not
    valid = 1'b0; FlagsWrite = 1'b1; ALUFlags = 4'b1000; step();
    exp_pc += 4;
    check("flags_n", {28'b0, flags}, 32'h8);
    FlagsWrite = 1'b0; issue(JLT, 18'h200); step();
    exp_pc = tgt(exp_pc, 18'h200);
    check("jlt_pc", pc, exp_pc);
    check("jlt_taken", {31'b0, taken}, 32'h1);
    issue(JGE, 18'h300); step();
    exp_pc += 4;
    check("jge_pc", pc, exp_pc);
    check("jge_taken", {31'b0, taken}, 32'h0);
    // Unknown opcode is sequential
    issue(4'b0011, 18'h300); step();
    exp_pc += 4;
    check("nop_pc", pc, exp_pc);
    // Immediate of all ones (-1 in relative builds)
    issue(JMP, 18'h3FFFF); step();
    exp_pc = tgt(exp_pc, 18'h3FFFF);
    check("jmp_m1_pc", pc, exp_pc);
    check("jmp_m1_taken", {31'b0, taken}, 32'h1);

    // Five calls into a four-deep stack, then five returns
    for (int k = 0; k < 5; k++) begin
      ra[k] = exp_pc + 4;
      issue(CALL, 18'(32'h1000 * (k + 1))); step();
      exp_pc = tgt(exp_pc, 18'(32'h1000 * (k + 1)));
      check("call_pc", pc, exp_pc);
      check("call_taken", {31'b0, taken}, 32'h1);
    end
    check("ovf_set", {31'b0, ovf}, 32'h1);
    check("udf_clear", {31'b0, udf}, 32'h0);
    for (int k = 0; k < 4; k++) begin
      issue(RET, 18'h0); step();
      exp_pc = ra[4 - k];
      check("ret_pc", pc, exp_pc);
      check("ret_taken", {31'b0, taken}, 32'h1);
    end
    issue(RET, 18'h0); step();
    exp_pc += 4;
    check("ret_empty_pc", pc, exp_pc);
    check("ret_empty_taken", {31'b0, taken}, 32'h0);
    check("udf_set", {31'b0, udf}, 32'h1);

    // Stalled CALL waits, then executes once; RET returns to CALL+4
    stall = 1'b1; issue(CALL, 18'h2400);
    for (int k = 0; k < 2; k++) begin
      step();
      check("stall_pc", pc, exp_pc);
      check("stall_taken", {31'b0, taken}, 32'h0);
    end
    stall = 1'b0; ra0 = exp_pc + 4; step();
    exp_pc = tgt(exp_pc, 18'h2400);
    check("call_after_stall_pc", pc, exp_pc);
    issue(RET, 18'h0); step();
    exp_pc = ra0;
    check("ret_after_stall_pc", pc, exp_pc);
    issue(RET, 18'h0); step();
    exp_pc += 4;
    check("single_push_pc", pc, exp_pc);
    check("single_push_taken", {31'b0, taken}, 32'h0);

    // Fill one entry, then a stalled JMP interrupted by reset
    issue(CALL, 18'h3000); step();
    stall = 1'b1; issue(JMP, 18'h500); step();
    check("stall_jmp_taken1", {31'b0, taken}, 32'h0);
    reset = 1'b1; step();
    check("midrst_pc", pc, 32'h0);
    check("midrst_taken", {31'b0, taken}, 32'h0);
    check("midrst_ovf", {31'b0, ovf}, 32'h0);
    check("midrst_udf", {31'b0, udf}, 32'h0);
    reset = 1'b0; step();
    check("stall_jmp_taken3", {31'b0, taken}, 32'h0);
    check("stall_jmp_pc3", pc, 32'h0);
    // Stack must be empty after reset: RET underflows
    stall = 1'b0; issue(RET, 18'h0); step();
    check("post_rst_ret_pc", pc, 32'h4);
    check("post_rst_ret_taken", {31'b0, taken}, 32'h0);
    check("post_rst_udf", {31'b0, udf}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_control_unit.md
BRANCH_CONTROL_UNIT -- requirements
Module: branch_control_unit

Interface
REQ-001 Parameter PC_W, default 32, program counter width in bits.
REQ-002 Parameter IMM_W, default 18, branch immediate width; IMM_W <= PC_W SHALL hold (elaboration error otherwise).
REQ-003 Parameter RAS_DEPTH, default 4, return-address stack entries; power of two, >= 2.
REQ-004 Parameter RESET_PC, default 0, PC value after reset.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  run enable; PC and stack advance only while high.
REQ-008 stall  input  1  pipeline stall; holds PC and stack.
REQ-009 valid  input  1  Id/Imm hold a decoded instruction.
REQ-010 Id  input  4  instruction class opcode.
REQ-011 Imm  input  IMM_W  branch target or offset.
REQ-012 FlagsWrite  input  1  load ALUFlags into flag register.
REQ-013 ALUFlags  input  4  {N,Z,C,V}, bit 3 = N, bit 2 = Z.
REQ-014 PCNext  output  PC_W  current registered PC.
REQ-015 Flags  output  4  registered flags.
REQ-016 FlagZero  output  1  equals Flags[2].
REQ-017 taken  output  1  one-cycle pulse: PCNext is a redirected target.
REQ-018 ras_ovf / ras_udf  output  1 each  sticky stack overflow / underflow.

Function
REQ-019 Advance when start=1, stall=0, reset=0; otherwise PC, stack, taken=0 hold.
REQ-020 Flag register loads ALUFlags on FlagsWrite regardless of start/stall; branches evaluate the pre-edge registered Flags, never same-cycle ALUFlags.
REQ-021 Sequential PC = PCNext + 4 modulo 2^PC_W (0xFFFF_FFFC wraps to 0).
REQ-022 Opcodes on advance with valid=1: 1100 JMP always; 1101 JEQ if Z; 1110 JNE if !Z; 1010 JLT if N!=V; 1001 JGE if N==V; 1111 CALL pushes PCNext+4 then jumps; 1011 RET pops into PC; any other opcode or valid=0 gives sequential PC.
REQ-023 Target formation per REQ-032/033; taken registered, asserted exactly the cycle PCNext shows a non-sequential value (1-cycle latency).
REQ-024 Stack push when full: overwrite oldest entry (circular), count stays RAS_DEPTH, set ras_ovf.
REQ-025 RET when empty: sequential PC, taken=0, set ras_udf, count stays 0.
REQ-026 Stack is LIFO; CALL immediately followed by RET returns to CALL address + 4.
REQ-027 Stalled cycle with a pending branch opcode SHALL NOT push/pop; branch executes on first non-stalled cycle.

Reset
REQ-028 reset overrides all inputs including stall and start.
REQ-029 After reset: PCNext=RESET_PC, Flags=0, FlagZero=0, taken=0, stack empty, ras_ovf=0, ras_udf=0.
REQ-030 Reset mid-branch or mid-stall discards the pending operation; no push/pop occurs that cycle.
REQ-031 Stack entry contents need not be reset; only pointer and count.

Configuration
REQ-032 Macro BCU_RELATIVE_BRANCH_EN defined: target = PCNext + (sign-extended Imm << 2), modulo 2^PC_W.
REQ-033 Macro undefined: target = zero-extended Imm (absolute byte address).

Structure
REQ-034 Package bcu_pkg holds opcode enum, flag bit indices (N=3,Z=2,C=1,V=0), INSTR_BYTES=4.
REQ-035 Sub-module return_stack (params WIDTH, DEPTH; push, pop, data, full, empty) implements the stack; flops use the team's enabled-reset register primitive.

Verification
REQ-036 Reset then start=1, no valid, 3 cycles -> PCNext 0,4,8,12; taken=0.
REQ-037 FlagsWrite with ALUFlags=0100, next cycle JEQ Imm=0x40 (absolute) -> PCNext=0x40, taken=1 one cycle; JNE same flags -> PC+4.
REQ-038 RELATIVE build, PCNext=0x100, JMP Imm=0x3FFFF (-1) -> PCNext=0xFC.
REQ-039 Five CALLs (RAS_DEPTH=4) then five RETs -> four correct returns, ras_ovf=1, fifth RET sequential with ras_udf=1.
REQ-040 JMP held with stall=1 for 3 cycles, reset asserted on cycle 2 -> PCNext=RESET_PC, stack empty, taken never asserted.
